tx_rr_arbiter: RTL and testbench
================================

Name: tx_rr_arbiter

Overview:
- Round-robin arbiter that shares one valid/ready transmit channel (valid_o, data_o, ready_i) among NUM_REQ requesters.
- Each requester presents its own valid/data/ready triple.
- The granted owner holds the channel for a burst of up to BURST_MAX beats, then the grant rotates.
- The block sits between the requester FSMs and the downstream receiver, and owns the registered output stage.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 2, beat width in bits.
- BURST_MAX, 4, maximum beats per grant (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active high.
- req_valid_i  in  NUM_REQ  per-requester beat valid.
- req_data_i  in  NUM_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W].
- req_ready_o  out  NUM_REQ  per-requester beat accept; at most one bit high.
- valid_o  out  1  output beat valid (registered).
- data_o  out  DATA_W  output beat data (registered).
- ready_i  in  1  downstream accept.
- grant_o  out  NUM_REQ  one-hot current owner (registered); 0 when idle.
- busy_o  out  1  high while in OWN state.

Behaviour:
- Reset (synchronous, active high) values:
  - state=IDLE, valid_o=0, data_o=0, grant_o=0, busy_o=0, req_ready_o=0.
  - Priority pointer=0, beat_cnt=0.
  - Reset mid-burst drops valid_o immediately at the clock edge; the in-flight beat is discarded.
- Output register load condition: load = !valid_o || ready_i.
- Output handshake:
  - Downstream transfer occurs when valid_o && ready_i.
  - data_o is held stable while valid_o && !ready_i.
- IDLE state:
  - If any req_valid_i is high, select the first requester at or after the pointer, in ascending index order with wrap.
  - Register grant_o to that requester; go to OWN; clear beat_cnt.
  - Otherwise stay in IDLE.
  - req_ready_o = 0 throughout IDLE.
- OWN state, owner index k:
  - req_ready_o[k] = load (combinational); all other bits 0.
  - Requester beat accepted when req_ready_o[k] && req_valid_i[k]. On accept:
    - data_o <= req_data_i[k], valid_o <= 1.
    - beat_cnt increments.
  - If load and no accept: valid_o <= 0.
- Release conditions (OWN -> IDLE next cycle, pointer <= k+1 mod NUM_REQ, grant_o <= 0):
  - (a) an accept makes beat_cnt reach BURST_MAX, or
  - (b) load && !req_valid_i[k] (owner has nothing to send while the channel is free).
- No release while load=0: the owner keeps the grant through downstream backpressure.
- Latency:
  - req_valid_i[i] rises at cycle t in IDLE -> grant_o[i] and req_ready_o[i] at t+1 -> valid_o at t+2.
  - Within a burst with ready_i=1: one beat per cycle.
  - Arbitration costs exactly one IDLE cycle between grants.
- Release and output drain:
  - The last beat of a burst stays in the output register after release and drains normally.
  - IDLE does not clear valid_o; only a transfer with no reload does.
- Simultaneous requests: the pointer alone decides; the losing requester waits with valid held and receives no ready.
- Requesters must hold req_valid/req_data until accepted. Dropping valid before accept is legal; it triggers release condition (b) when the requester is the owner.
- beat_cnt width = clog2(BURST_MAX+1); no wrap, since release occurs at BURST_MAX.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles with req_valid_i=4'b1111 -> all outputs 0. After release, grant_o=0001 at the first cycle, valid_o at the second.
2. Single requester 2 streams data 1,2,3,0,1 with ready_i=1 and BURST_MAX=4:
   - data_o=1,2,3,0 on consecutive cycles.
   - grant_o drops for one cycle, then regrants 0100 (no other requester); data_o=1 follows.
3. All four requesting continuously -> grant order 0001, 0010, 0100, 1000, 0001, each holding 4 beats separated by a single idle cycle.
4. Backpressure: ready_i=0 for 5 cycles mid-burst -> data_o held constant, req_ready_o=0, grant unchanged. On ready_i=1 the burst resumes with no lost or duplicated beat.
5. Owner 1 drops req_valid after 2 beats while requester 3 is waiting -> release, pointer=2, next grant 1000.
6. Reset asserted while valid_o=1 and ready_i=0 -> next cycle valid_o=0, grant_o=0, pointer=0.

Source files
------------

// File: rtl/tx_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready transmit channel among
// NUM_REQ requesters; each grant carries a burst of up to BURST_MAX beats.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no owner; pick first valid requester at/after the pointer
// ST_OWN  | owner_q holds the channel until burst end or it runs dry
module tx_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 2,
    parameter int BURST_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      valid_o,
    output logic [DATA_W-1:0]         data_o,
    input  logic                      ready_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BURST_MAX - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               valid_d;
    logic [DATA_W-1:0]  data_d;
    logic [NUM_REQ-1:0] grant_d;
    logic               load;
    logic               accept;
    logic [DATA_W-1:0]  owner_data;

    assign load       = !valid_o || ready_i;
    assign owner_data = req_data_i[int'(owner_q)*DATA_W +: DATA_W];
    assign accept     = (state_q == ST_OWN) && load && req_valid_i[owner_q];
    assign busy_o     = (state_q == ST_OWN);

    // Scan requesters starting at the pointer, wrapping past the top index.
    always_comb begin
        int cand;
        cand      = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!sel_found && req_valid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        beat_cnt_d  = beat_cnt_q;
        grant_d     = grant_o;
        valid_d     = valid_o;
        data_d      = data_o;
        req_ready_o = '0;

        // The output register is shared by both states so the last beat of a
        // burst keeps draining through the IDLE arbitration cycle.
        if (accept) begin
            valid_d = 1'b1;
            data_d  = owner_data;
        end else if (load) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d          = ST_OWN;
                    owner_d          = sel_idx;
                    beat_cnt_d       = '0;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                end
            end
            ST_OWN: begin
                req_ready_o[owner_q] = load;
                if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
                if ((accept && (beat_cnt_q == CNT_PRE)) ||
                    (load && !req_valid_i[owner_q])) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
            grant_o    <= '0;
            valid_o    <= 1'b0;
            data_o     <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
            grant_o    <= grant_d;
            valid_o    <= valid_d;
            data_o     <= data_d;
        end
    end

endmodule

// File: tb/tb_tx_rr_arbiter.sv
// Directed bench for tx_rr_arbiter (NUM_REQ=4, DATA_W=2, BURST_MAX=4) with
// hand-computed expectations checked by immediate assertions.
module tb_tx_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid_i;
    logic [7:0] req_data_i;
    logic [3:0] req_ready_o;
    logic       valid_o;
    logic [1:0] data_o;
    logic       ready_i;
    logic [3:0] grant_o;
    logic       busy_o;

    int tests = 0;
    int fails = 0;

    tx_rr_arbiter #(.NUM_REQ(4), .DATA_W(2), .BURST_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid_i(req_valid_i),
        .req_data_i (req_data_i),
        .req_ready_o(req_ready_o),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .ready_i    (ready_i),
        .grant_o    (grant_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] eg;

        // 1: reset with all requesters active, then first grant/beat latency
        rst         = 1'b1;
        req_valid_i = 4'b1111;
        req_data_i  = 8'b11_10_01_01;
        ready_i     = 1'b1;
        tick();
        tick();
        chk("t1_rst_valid", 8'(valid_o), 8'h0);
        chk("t1_rst_data",  8'(data_o), 8'h0);
        chk("t1_rst_grant", 8'(grant_o), 8'h0);
        chk("t1_rst_busy",  8'(busy_o), 8'h0);
        chk("t1_rst_ready", 8'(req_ready_o), 8'h0);
        rst = 1'b0;
        tick();
        chk("t1_grant0",    8'(grant_o), 8'b0001);
        chk("t1_busy",      8'(busy_o), 8'h1);
        chk("t1_valid_lo",  8'(valid_o), 8'h0);
        chk("t1_ready0",    8'(req_ready_o), 8'b0001);
        tick();
        chk("t1_valid_hi",  8'(valid_o), 8'h1);
        chk("t1_data",      8'(data_o), 8'h1);

        // 2: requester 2 alone streams 1,2,3,0 then regrants for 1
        rst = 1'b1;
        req_valid_i = 4'b0000;
        tick();
        rst = 1'b0;
        chk("t2_rst_valid", 8'(valid_o), 8'h0);
        req_valid_i = 4'b0100;
        req_data_i  = 8'b00_01_00_00;
        tick();
        chk("t2_grant",     8'(grant_o), 8'b0100);
        chk("t2_ready",     8'(req_ready_o), 8'b0100);
        tick();
        chk("t2_beat1",     8'(data_o), 8'd1);
        chk("t2_beat1_v",   8'(valid_o), 8'h1);
        req_data_i[5:4] = 2'd2;
        tick();
        chk("t2_beat2",     8'(data_o), 8'd2);
        req_data_i[5:4] = 2'd3;
        tick();
        chk("t2_beat3",     8'(data_o), 8'd3);
        req_data_i[5:4] = 2'd0;
        tick();
        chk("t2_beat4",     8'(data_o), 8'd0);
        chk("t2_beat4_v",   8'(valid_o), 8'h1);
        chk("t2_rel_grant", 8'(grant_o), 8'h0);
        chk("t2_rel_ready", 8'(req_ready_o), 8'h0);
        req_data_i[5:4] = 2'd1;
        tick();
        chk("t2_regrant",   8'(grant_o), 8'b0100);
        chk("t2_gap_valid", 8'(valid_o), 8'h0);
        tick();
        chk("t2_beat5",     8'(data_o), 8'd1);
        chk("t2_beat5_v",   8'(valid_o), 8'h1);
        req_valid_i = 4'b0000;
        tick();
        chk("t2_dry_grant", 8'(grant_o), 8'h0);
        chk("t2_dry_busy",  8'(busy_o), 8'h0);
        chk("t2_dry_valid", 8'(valid_o), 8'h0);

        // 3: all four requesting, grants rotate with one idle cycle between
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid_i = 4'b1111;
        req_data_i  = 8'b11_10_01_00;
        for (int g = 0; g < 5; g++) begin
            eg = 4'b0001 << (g % 4);
            tick();
            chk($sformatf("t3_grant%0d", g), 8'(grant_o), 8'(eg));
            chk($sformatf("t3_gap_v%0d", g), 8'(valid_o), 8'h0);
            for (int b = 1; b <= 4; b++) begin
                tick();
                chk($sformatf("t3_g%0d_b%0d_data", g, b), 8'(data_o), 8'(g % 4));
                chk($sformatf("t3_g%0d_b%0d_valid", g, b), 8'(valid_o), 8'h1);
                chk($sformatf("t3_g%0d_b%0d_grant", g, b), 8'(grant_o),
                    (b == 4) ? 8'h0 : 8'(eg));
            end
        end

        // 4: backpressure mid-burst holds data and grant, no lost/dup beats
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid_i = 4'b0001;
        req_data_i  = 8'b00_00_00_01;
        tick();
        chk("t4_grant",     8'(grant_o), 8'b0001);
        tick();
        chk("t4_beat1",     8'(data_o), 8'd1);
        req_data_i[1:0] = 2'd2;
        ready_i = 1'b0;
        #1;
        chk("t4_bp_ready",  8'(req_ready_o), 8'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("t4_hold_data%0d", c),  8'(data_o), 8'd1);
            chk($sformatf("t4_hold_valid%0d", c), 8'(valid_o), 8'h1);
            chk($sformatf("t4_hold_grant%0d", c), 8'(grant_o), 8'b0001);
            chk($sformatf("t4_hold_ready%0d", c), 8'(req_ready_o), 8'h0);
        end
        ready_i = 1'b1;
        #1;
        chk("t4_resume_ready", 8'(req_ready_o), 8'b0001);
        tick();
        chk("t4_beat2",     8'(data_o), 8'd2);
        req_data_i[1:0] = 2'd3;
        tick();
        chk("t4_beat3",     8'(data_o), 8'd3);
        req_data_i[1:0] = 2'd0;
        tick();
        chk("t4_beat4",     8'(data_o), 8'd0);
        chk("t4_rel_grant", 8'(grant_o), 8'h0);

        // 5: owner 1 runs dry after 2 beats; pointer moves to 2 so 3 beats 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid_i = 4'b1010;
        req_data_i  = 8'b10_00_11_00;
        tick();
        chk("t5_grant1",    8'(grant_o), 8'b0010);
        tick();
        chk("t5_beat1",     8'(data_o), 8'd3);
        tick();
        chk("t5_beat2",     8'(data_o), 8'd3);
        req_valid_i = 4'b1000;
        tick();
        chk("t5_rel_grant", 8'(grant_o), 8'h0);
        chk("t5_rel_valid", 8'(valid_o), 8'h0);
        req_valid_i = 4'b1011;
        tick();
        chk("t5_grant3",    8'(grant_o), 8'b1000);
        tick();
        chk("t5_beat3",     8'(data_o), 8'd2);
        chk("t5_beat3_v",   8'(valid_o), 8'h1);

        // 6: reset while valid_o=1 under backpressure
        ready_i = 1'b0;
        tick();
        chk("t6_held_valid", 8'(valid_o), 8'h1);
        rst = 1'b1;
        tick();
        chk("t6_rst_valid", 8'(valid_o), 8'h0);
        chk("t6_rst_grant", 8'(grant_o), 8'h0);
        chk("t6_rst_busy",  8'(busy_o), 8'h0);
        chk("t6_rst_ready", 8'(req_ready_o), 8'h0);
        rst     = 1'b0;
        ready_i = 1'b1;
        tick();
        chk("t6_ptr_zero",  8'(grant_o), 8'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
